// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb: NUMB x SIZE register file, two combinational read ports,
// two write ports (W1 wins on same-address collision), and a per-register
// pending-write scoreboard with a registered pending count.
// Register 0 is hard-wired zero and can never be pending.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data and
// write-clears-busy onto the read ports (zero-cycle write-to-read).

// One storage entry (data word + pending bit) for a nonzero address.
module regfile_2w2r_sb_entry #(
  parameter int SIZE = 64
) (
  input  logic            Clk,
  input  logic            rst_n,
  input  logic            w0_hit,
  input  logic            w1_hit,
  input  logic            iss_hit,
  input  logic [SIZE-1:0] w0_data,
  input  logic [SIZE-1:0] w1_data,
  output logic [SIZE-1:0] q,
  output logic            pend,
  output logic            pend_nxt
);
  // A new issue overrides a same-cycle clear: the new producer owns the reg.
  assign pend_nxt = iss_hit | (pend & ~(w0_hit | w1_hit));

  // Data and pending-bit state; W1 has priority over W0.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (w1_hit)      q <= w1_data;
      else if (w0_hit) q <= w0_data;
      pend <= pend_nxt;
    end
  end
endmodule

module regfile_2w2r_sb #(
  parameter int ADDR = 5,
  parameter int NUMB = 1 << ADDR,
  parameter int SIZE = 64
) (
  input  logic            Clk,
  input  logic            rst_n,
  input  logic [ADDR-1:0] R_Addr_A,
  input  logic [ADDR-1:0] R_Addr_B,
  output logic [SIZE-1:0] R_Data_A,
  output logic [SIZE-1:0] R_Data_B,
  output logic            Busy_A,
  output logic            Busy_B,
  input  logic            W0_en,
  input  logic [ADDR-1:0] W0_Addr,
  input  logic [SIZE-1:0] W0_Data,
  input  logic            W1_en,
  input  logic [ADDR-1:0] W1_Addr,
  input  logic [SIZE-1:0] W1_Data,
  input  logic            Iss_en,
  input  logic [ADDR-1:0] Iss_Addr,
  output logic [ADDR:0]   Pend_cnt
);
  logic [NUMB-1:1]           w0_hit, w1_hit, iss_hit, pend_q, pend_nxt;
  logic [NUMB-1:0]           pend_all;
  logic [NUMB-1:0][SIZE-1:0] mem_q;
  logic [ADDR:0]             cnt_nxt;

  assign mem_q[0] = '0;
  assign pend_all = {pend_q, 1'b0};

  // Entries 1..NUMB-1; address decode folds in the nonzero-address rule.
  for (genvar i = 1; i < NUMB; i++) begin : g_ent
    assign w0_hit[i]  = W0_en  && (W0_Addr  == ADDR'(i));
    assign w1_hit[i]  = W1_en  && (W1_Addr  == ADDR'(i));
    assign iss_hit[i] = Iss_en && (Iss_Addr == ADDR'(i));

    regfile_2w2r_sb_entry #(.SIZE(SIZE)) u_ent (
      .Clk      (Clk),
      .rst_n    (rst_n),
      .w0_hit   (w0_hit[i]),
      .w1_hit   (w1_hit[i]),
      .iss_hit  (iss_hit[i]),
      .w0_data  (W0_Data),
      .w1_data  (W1_Data),
      .q        (mem_q[i]),
      .pend     (pend_q[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  // Popcount of next-state pending bits so the count tracks the bits exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < NUMB; i++) cnt_nxt = cnt_nxt + {{ADDR{1'b0}}, pend_nxt[i]};
  end

  // Registered pending count.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) Pend_cnt <= '0;
    else        Pend_cnt <= cnt_nxt;
  end

  // One read port: returns {busy, data} for an address.
  function automatic logic [SIZE:0] rd_port(input logic [ADDR-1:0] a);
    logic [SIZE-1:0] d;
    logic            b;
    d = mem_q[a];
    b = pend_all[a];
`ifdef REGFILE_BYPASS_EN
    if (a != '0) begin
      if (W1_en && W1_Addr == a)      d = W1_Data;
      else if (W0_en && W0_Addr == a) d = W0_Data;
      if ((W1_en && W1_Addr == a) || (W0_en && W0_Addr == a))
        b = Iss_en && (Iss_Addr == a);
    end
`endif
    // Outputs read as zero while reset is held, even with forwarding active.
    if (!rst_n) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  // Combinational read ports.
  always_comb begin
    {Busy_A, R_Data_A} = rd_port(R_Addr_A);
    {Busy_B, R_Data_B} = rd_port(R_Addr_B);
  end
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Scoreboard bench for regfile_2w2r_sb: the driver pushes expected read-port
// values computed from an array model; a negedge monitor pops and compares.
module tb_regfile_2w2r_sb;
  logic        Clk = 1'b0, rst_n = 1'b0;
  logic [4:0]  R_Addr_A = '0, R_Addr_B = '0;
  logic [63:0] R_Data_A, R_Data_B;
  logic        Busy_A, Busy_B;
  logic        W0_en = 1'b0, W1_en = 1'b0, Iss_en = 1'b0;
  logic [4:0]  W0_Addr = '0, W1_Addr = '0, Iss_Addr = '0;
  logic [63:0] W0_Data = '0, W1_Data = '0;
  logic [5:0]  Pend_cnt;

  regfile_2w2r_sb dut (
    .Clk(Clk), .rst_n(rst_n),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .Busy_A(Busy_A), .Busy_B(Busy_B),
    .W0_en(W0_en), .W0_Addr(W0_Addr), .W0_Data(W0_Data),
    .W1_en(W1_en), .W1_Addr(W1_Addr), .W1_Data(W1_Data),
    .Iss_en(Iss_en), .Iss_Addr(Iss_Addr), .Pend_cnt(Pend_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] da, db;
    logic        ba, bb;
    logic [5:0]  pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [63:0] mdl_mem[32];
  bit          mdl_pend[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the driver expected for this cycle.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rdata_a", R_Data_A, e.da);
      chk("rdata_b", R_Data_B, e.db);
      chk("busy_a", {63'd0, Busy_A}, {63'd0, e.ba});
      chk("busy_b", {63'd0, Busy_B}, {63'd0, e.bb});
      chk("pend_cnt", {58'd0, Pend_cnt}, {58'd0, e.pc});
    end
  end

  function automatic bit wr_hit(input logic [4:0] a);
    return (W0_en && W0_Addr == a) || (W1_en && W1_Addr == a);
  endfunction

  function automatic logic [63:0] m_data(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (W1_en && W1_Addr == a) return W1_Data;
    if (W0_en && W0_Addr == a) return W0_Data;
`endif
    return mdl_mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_hit(a)) return Iss_en && Iss_Addr == a;
`endif
    return mdl_pend[a];
  endfunction

  function automatic logic [5:0] m_cnt();
    int n = 0;
    foreach (mdl_pend[i]) n += mdl_pend[i];
    return 6'(n);
  endfunction

  task automatic push_exp(input bit in_rst);
    exp_t e;
    if (in_rst) begin
      e.da = '0; e.db = '0; e.ba = 1'b0; e.bb = 1'b0; e.pc = '0;
    end else begin
      e.da = m_data(R_Addr_A); e.db = m_data(R_Addr_B);
      e.ba = m_busy(R_Addr_A); e.bb = m_busy(R_Addr_B);
      e.pc = m_cnt();
    end
    sb.push_back(e);
  endtask

  task automatic set_in(input bit w0e, input logic [4:0] w0a, input logic [63:0] w0d,
                        input bit w1e, input logic [4:0] w1a, input logic [63:0] w1d,
                        input bit ie, input logic [4:0] ia,
                        input logic [4:0] ra, input logic [4:0] rb);
    W0_en = w0e; W0_Addr = w0a; W0_Data = w0d;
    W1_en = w1e; W1_Addr = w1a; W1_Data = w1d;
    Iss_en = ie; Iss_Addr = ia;
    R_Addr_A = ra; R_Addr_B = rb;
  endtask

  // One normal cycle: drive, expect, clock, then advance the model.
  task automatic cyc(input bit w0e, input logic [4:0] w0a, input logic [63:0] w0d,
                     input bit w1e, input logic [4:0] w1a, input logic [63:0] w1d,
                     input bit ie, input logic [4:0] ia,
                     input logic [4:0] ra, input logic [4:0] rb);
    set_in(w0e, w0a, w0d, w1e, w1a, w1d, ie, ia, ra, rb);
    push_exp(1'b0);
    @(posedge Clk);
    if (w0e && w0a != 0) begin mdl_mem[w0a] = w0d; mdl_pend[w0a] = 0; end
    if (w1e && w1a != 0) begin mdl_mem[w1a] = w1d; mdl_pend[w1a] = 0; end
    if (ie && ia != 0) mdl_pend[ia] = 1;
    #1;
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  task automatic clr_model();
    foreach (mdl_mem[i]) begin mdl_mem[i] = '0; mdl_pend[i] = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_model();
    repeat (2) @(posedge Clk);
    #1 rst_n = 1'b1;

    // Reset state across every address.
    for (int i = 1; i < 32; i++) rd(5'(i), 5'(32 - i));

    // Basic write and register 0.
    cyc(1, 5, 64'hDEADBEEF_00000001, 0, 0, 0, 0, 0, 5, 0);
    rd(5, 5);
    cyc(1, 0, '1, 1, 0, '1, 1, 0, 0, 0);
    rd(0, 0);

    // Collision and disjoint dual write.
    cyc(1, 9, 64'h11, 1, 9, 64'h22, 0, 0, 9, 9);
    rd(9, 0);
    cyc(1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 3, 4);
    rd(3, 4);

    // Scoreboard set / clear / set-wins.
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);
    cyc(0, 0, 0, 0, 0, 0, 1, 8, 7, 8);
    cyc(1, 7, 64'h77, 0, 0, 0, 0, 0, 7, 8);
    cyc(0, 0, 0, 1, 8, 64'h88, 1, 8, 7, 8);
    rd(7, 8);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);  // re-issue 7
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 8);  // already pending, stays 1

    // Bypass case (also the no-bypass old-value case).
    cyc(0, 0, 0, 1, 12, 64'hABC, 0, 0, 0, 12);
    rd(12, 12);
    cyc(1, 12, 64'h5, 0, 0, 0, 1, 12, 12, 12);  // write+issue same reg
    rd(12, 0);

    // Async reset between edges with writes and issues active.
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 5, 9);
    set_in(1, 10, 64'hAA, 1, 11, 64'hBB, 1, 6, 10, 3);
    rst_n = 1'b0;
    clr_model();
    push_exp(1'b1);
    @(posedge Clk);
    #1 rst_n = 1'b1;
    rd(10, 3);
    cyc(1, 10, 64'h1234, 0, 0, 0, 0, 0, 10, 9);
    rd(10, 9);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
          $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
          $urandom_range(0, 2) != 0, 5'($urandom),
          5'($urandom), 5'($urandom));
    end

    rd(0, 0);
    repeat (2) @(posedge Clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
